// File: rtl/fifo_burst_reader.sv
// Burst-draining read master for a 1-cycle-latency FIFO.
// Emits full or timed-out partial bursts as a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_uw,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   rd_left, rd_left_n;
  logic [CW-1:0]   out_left, out_left_n;
  logic [TW-1:0]   timer, timer_n;
  logic            inflight;
  logic [1:0]      occ;
  logic [1:0]      fill;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic            xfer, space, timeout_hit;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid & (out_left == CW'(1));
  assign busy    = (state != IDLE);
  assign xfer    = m_valid & m_ready;

  // Words buffered plus the one still on its way back from the FIFO.
  assign fill  = occ + {1'b0, inflight};
  assign space = (fill < 2'd2) | ((fill == 2'd2) & xfer);

  assign fifo_rd_en = (state == READ) & (rd_left != '0)
                    & ~fifo_empty & space;

  assign timeout_hit = (TIMEOUT != 0) & (fifo_uw != '0)
                     & (timer == TMAX);

  always_comb begin
    state_n    = state;
    rd_left_n  = rd_left;
    out_left_n = out_left;
    timer_n    = timer;
    if (flush) begin
      state_n    = IDLE;
      rd_left_n  = '0;
      out_left_n = '0;
      timer_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_uw >= BLEN) begin
            state_n    = READ;
            rd_left_n  = BLEN;
            out_left_n = BLEN;
            timer_n    = '0;
          end else if (timeout_hit) begin
            state_n    = READ;
            rd_left_n  = fifo_uw;
            out_left_n = fifo_uw;
            timer_n    = '0;
          end else if (fifo_uw == '0) begin
            timer_n = '0;
          end else if (timer != TMAX) begin
            timer_n = timer + 1'b1;
          end
        end
        READ: begin
          timer_n = '0;
          if (fifo_rd_en) rd_left_n = rd_left - 1'b1;
          if (xfer) begin
            out_left_n = out_left - 1'b1;
            if (out_left == CW'(1)) state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_left  <= '0;
      out_left <= '0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      rd_left  <= rd_left_n;
      out_left <= out_left_n;
      timer    <= timer_n;
    end
  end

  // Two-entry skid buffer; head_q always holds the word on the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (flush) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, inflight} - {1'b0, xfer};
      if (xfer) head_q <= tail_q;
      if (inflight) begin
        if (occ == {1'b0, xfer}) head_q <= fifo_data_out;
        else                     tail_q <= fifo_data_out;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a queue-based FIFO model
// and a burst/order reference derived from the written word log.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int UW = AW + 1;
  localparam int BL = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic [UW-1:0] fifo_uw = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;

  logic          rd0, v0, l0, b0;
  logic [DW-1:0] d0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty),
    .fifo_uw(fifo_uw),
    .flush(flush),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
  );

  // Partial bursts disabled: a standing residue of 5 must never be read.
  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BURST_LEN(BL), .TIMEOUT(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .fifo_rd_en(rd0),
    .fifo_data_out('0),
    .fifo_empty(1'b0),
    .fifo_uw(UW'(5)),
    .flush(1'b0),
    .m_data(d0), .m_valid(v0),
    .m_ready(1'b1), .m_last(l0),
    .busy(b0)
  );

  int checks = 0;
  int fails = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] wlog[$];
  logic [DW-1:0] wr_todo[$];
  logic [DW-1:0] obs_d[$];
  bit            obs_l[$];
  int            obs_t[$];

  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_clr = 1'b0;

  int  cyc = 0;
  int  rd_cnt, first_rd, first_uw;
  bit  stall_prev, rdy_rand, occ_chk;
  logic [DW-1:0] pd;
  logic pl;
  bit  last_busy, last_valid;
  int  n_rd0 = 0;
  bit  b0_seen = 0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0)
        fifo_data_out <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
    end
    fifo_uw    <= UW'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst && rd0) n_rd0++;
    if (!rst && b0) b0_seen = 1;
  end

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_counts();
    obs_d.delete();
    obs_l.delete();
    obs_t.delete();
    rd_cnt = 0;
    first_rd = -1;
    first_uw = -1;
    stall_prev = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, pd);
      check("hold_last", m_last, pl);
    end
    if (occ_chk)
      check("occ_bound", (rd_cnt - obs_d.size()) <= 2, 1);
    if (fifo_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (fifo_uw != '0 && first_uw < 0) first_uw = cyc;
    if (m_valid && m_ready && !flush) begin
      obs_d.push_back(m_data);
      obs_l.push_back(m_last);
      obs_t.push_back(cyc);
    end
    stall_prev = m_valid && !m_ready && !flush;
    pd = m_data;
    pl = m_last;
    last_busy = busy;
    last_valid = m_valid;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    if (wr_todo.size() > 0) begin
      wr_req = 1'b1;
      wr_data = wr_todo.pop_front();
      wlog.push_back(wr_data);
    end
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_xfers(int n, int bound);
    int k = 0;
    while (obs_d.size() < n && k < bound) begin
      tick();
      k++;
    end
    check("xfer_wait", obs_d.size() >= n, 1);
  endtask

  task automatic add_words(int n);
    for (int i = 0; i < n; i++) wr_todo.push_back($urandom);
  endtask

  // Expected stream: written words in order, m_last closing each burst.
  task automatic verify(string tag, int base, int n, int l1, int l2);
    bit lm[$];
    for (int i = 0; i < l1; i++) lm.push_back(i == l1 - 1);
    for (int i = 0; i < l2; i++) lm.push_back(i == l2 - 1);
    for (int i = 0; i < n && i < obs_d.size(); i++) begin
      check({tag, "_data"}, obs_d[i], wlog[base + i]);
      check({tag, "_last"}, obs_l[i], (i < lm.size()) ? lm[i] : 1'b0);
    end
  endtask

  task automatic scen_full(string tag);
    int base, gaps;
    reset_counts();
    base = wlog.size();
    add_words(BL);
    wait_xfers(BL, 300);
    tick();
    check({tag, "_busy_after"}, last_busy, 0);
    check({tag, "_count"}, obs_d.size(), BL);
    verify(tag, base, BL, BL, 0);
    check({tag, "_rd_pulses"}, rd_cnt, BL);
    if (obs_t.size() >= BL) begin
      check({tag, "_latency"}, obs_t[0] - first_rd, 2);
      gaps = 0;
      for (int i = 1; i < BL; i++)
        if (obs_t[i] - obs_t[i-1] != 1) gaps++;
      check({tag, "_rate"}, gaps, 0);
    end
  endtask

  initial begin
    int base, base2, rem, l1, k;
    rdy_rand = 0;
    occ_chk = 0;
    reset_counts();
    @(posedge clk);
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    scen_full("full");

    reset_counts();
    base = wlog.size();
    add_words(5);
    k = 0;
    while (first_rd < 0 && k < 300) begin
      tick();
      k++;
    end
    check("to_latency", first_rd - first_uw, TO);
    wait_xfers(5, 50);
    tick();
    check("to_busy_after", last_busy, 0);
    check("to_count", obs_d.size(), 5);
    verify("to", base, 5, 5, 0);

    reset_counts();
    base = wlog.size();
    add_words(2 * BL);
    wait_xfers(2 * BL, 400);
    tick();
    check("b2b_count", obs_d.size(), 2 * BL);
    check("b2b_rd_pulses", rd_cnt, 2 * BL);
    verify("b2b", base, 2 * BL, BL, BL);

    reset_counts();
    base = wlog.size();
    rdy_rand = 1;
    occ_chk = 1;
    add_words(BL);
    wait_xfers(BL, 800);
    rdy_rand = 0;
    occ_chk = 0;
    tick();
    tick();
    check("rnd_count", obs_d.size(), BL);
    check("rnd_rd_pulses", rd_cnt, BL);
    verify("rnd", base, BL, BL, 0);

    reset_counts();
    base = wlog.size();
    add_words(2 * BL);
    wait_xfers(6, 300);
    check("fl_pre_count", obs_d.size(), 6);
    verify("fl_pre", base, 6, BL, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("fl_valid", last_valid, 0);
    check("fl_busy", last_busy, 0);
    check("fl_lost_bound", rd_cnt <= 9, 1);
    base2 = base + rd_cnt;
    rem = 2 * BL - rd_cnt;
    l1 = (rem >= BL) ? BL : rem;
    reset_counts();
    wait_xfers(rem, 600);
    tick();
    check("fl_post_count", obs_d.size(), rem);
    verify("fl_post", base2, rem, l1, rem - l1);

    reset_counts();
    add_words(BL);
    wait_xfers(3, 300);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_valid", m_valid, 0);
    check("arst_last", m_last, 0);
    check("arst_data", m_data, 0);
    check("arst_busy", busy, 0);
    rst = 1'b0;
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    tick();
    scen_full("after_rst");

    check("t0_no_reads", n_rd0, 0);
    check("t0_never_busy", b0_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
